// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared state encoding and sizing helper for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  // Counter must be able to hold the value WIDTH
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational 1-bit full subtractor cell (x - y - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [CW-1:0]    r_cnt;
  logic             r_bor;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_out_ack;

  full_subtractor u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_out_ack = out_valid && out_ready;

  // Result is built MSB-side first so the LSB lands at bit 0 after WIDTH shifts
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)        w_state_next = S_SHIFT;
      S_SHIFT: if (r_cnt == c_last) w_state_next = S_DONE;
      S_DONE:  if (w_out_ack)       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_bor <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_cnt <= '0;
            r_bor <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_bor <= w_bout;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign diff   = {r_bor, r_res};
  assign borrow = r_bor;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and randomized self-checking bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   diff;
  logic         borrow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction, taken modulo 2^(W+1)
  function automatic logic [W:0] ref_diff(input int x, input int y);
    int e;
    e = x - y;
    return e[W:0];
  endfunction

  // One full transaction; stall = cycles out_ready is held low once out_valid rises
  task automatic run_op(input int ta, input int tb_v, input int stall);
    int         n;
    logic [W:0] exp;
    logic [W:0] held;
    exp = ref_diff(ta, tb_v);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    out_ready = (stall == 0);
    a        = W'(ta);
    b        = W'(tb_v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(W + 1));
    check("diff", 32'(diff), 32'(exp));
    check("borrow", 32'(borrow), 32'(ta < tb_v));
    check("borrow_eq_msb", 32'(borrow), 32'(diff[W]));
    held = diff;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_diff", 32'(diff), 32'(held));
    end
    out_ready = 1'b1;
    step();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_diff_held", 32'(diff), 32'(held));
  endtask

  initial begin
    logic [W:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    step();

    // Basic cases and extremes, out_ready held high
    run_op(0, 0, 0);
    run_op(0, 1, 0);
    run_op(1, 0, 0);
    run_op(1, 1, 0);
    run_op(15, 0, 0);
    run_op(0, 15, 0);
    run_op(9, 12, 0);
    check("lit_0_15", 32'(ref_diff(0, 15)), 32'h11);
    check("lit_9_12", 32'(ref_diff(9, 12)), 32'h1d);

    // Backpressure with noise on the input side
    out_ready = 1'b0;
    a = 4'd5;
    b = 4'd11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && checks < 100000) step();
    held = diff;
    check("bp_diff", 32'(held), 32'(ref_diff(5, 11)));
    for (int i = 0; i < 8; i++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = 1'($urandom);
      step();
      check("bp_hold_diff", 32'(diff), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset on the second SHIFT cycle
    a = 4'd7;
    b = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    run_op(7, 3, 0);
    check("abort_rerun", 32'(diff), 32'h04);

    // Exhaustive sweep with random output stalls
    for (int i = 0; i < 256; i++) begin
      run_op(i / 16, i % 16, int'($urandom_range(0, 3)));
    end

    // Random extra traffic
    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
